icebus_status_rx: RTL and testbench

Receive-side UART frame parser for the iCE motor-board bus. It deserialises the `rx` line, validates status frames sent by the motor boards, and emits one strobed status record per good frame. Those records carry position, velocity, displacement and current for one motor. The Avalon motor-control register bank consumes them directly to update its per-motor status arrays.

---
 rtl/icebus_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 123 ++++++++++++
 rtl/icebus_status_rx.sv | 167 ++++++++++++++++
 tb/tb_icebus_status_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/icebus_pkg.sv
// Shared definitions for the iCE motor-board bus receive path.
// No ports: frame constants plus the state encodings used by the byte
// receiver and the frame parser.
package icebus_pkg;

  localparam logic [7:0] SYNC_BYTE           = 8'h55;
  localparam int         FRAME_PAYLOAD_BYTES = 14;
  localparam int         TIMEOUT_BIT_TIMES   = 40;

  typedef enum logic [1:0] {
    HUNT,
    ID,
    PAYLOAD,
    CHECK
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first.
//
// Ports:
//   clock, reset        system clock, async active-high reset
//   rx                  raw UART line, idle high, asynchronous to clock
//   byte_valid          1-cycle pulse, byte_data holds a good byte
//   byte_data[7:0]      last received data byte (stable until the next byte)
//   byte_framing_error  1-cycle pulse, stop bit was sampled low
//
// state    | meaning
// ---------+----------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half a bit time into the start bit, glitch check
// RX_DATA  | sampling the 8 data bits one bit time apart
// RX_STOP  | sampling the stop bit, then back to idle
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_framing_error
);
  import icebus_pkg::*;

  localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             valid_nxt, ferr_nxt;

  // rx_prev lets idle detect a true falling edge, so a line held low after
  // a framing error does not retrigger a byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= RX_IDLE;
      cnt                <= '0;
      bit_idx            <= '0;
      shreg              <= '0;
      byte_valid         <= 1'b0;
      byte_framing_error <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      bit_idx            <= bit_idx_nxt;
      shreg              <= shreg_nxt;
      byte_valid         <= valid_nxt;
      byte_framing_error <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt = RX_START;
          cnt_nxt   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (rx_sync) begin
          state_nxt = RX_IDLE;
        end else begin
          state_nxt   = RX_DATA;
          cnt_nxt     = BIT_RELOAD;
          bit_idx_nxt = '0;
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          shreg_nxt = {rx_sync, shreg[7:1]};
          cnt_nxt   = BIT_RELOAD;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        // Returning to idle at the mid-stop sample re-arms the receiver
        // for a start bit that follows with zero idle time.
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = RX_IDLE;
          valid_nxt = rx_sync;
          ferr_nxt  = !rx_sync;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/icebus_status_rx.sv
// Status-frame parser for the iCE motor-board bus. Validates 17-byte frames
// (sync, ID, 14 payload bytes, XOR checksum) and publishes one status record
// per good frame.
//
// Ports:
//   clock, reset          system clock, async active-high reset
//   rx                    UART line from the motor boards
//   status_valid          1-cycle pulse, status_* just updated
//   status_motor[7:0]     motor ID of last good frame
//   status_position[31:0] / status_velocity[31:0] / status_displacement[31:0]
//   status_current[15:0]  signed fields of last good frame
//   frame_error           1-cycle pulse on a rejected frame
//   frame_count[15:0]     good-frame counter, wraps
//
// state   | meaning
// --------+--------------------------------------------------------
// HUNT    | discarding bytes until a sync byte arrives
// ID      | expecting the motor ID byte
// PAYLOAD | shifting in the 14 big-endian payload bytes
// CHECK   | expecting the checksum byte, accept or reject the frame
module icebus_status_rx #(
  parameter int CLOCK_SPEED_HZ   = 50_000_000,
  parameter int BAUD_RATE        = 2_000_000,
  parameter int NUMBER_OF_MOTORS = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx,
  output logic               status_valid,
  output logic [7:0]         status_motor,
  output logic signed [31:0] status_position,
  output logic signed [31:0] status_velocity,
  output logic signed [31:0] status_displacement,
  output logic signed [15:0] status_current,
  output logic               frame_error,
  output logic [15:0]        frame_count
);
  import icebus_pkg::*;

  localparam int CLKS_PER_BIT   = CLOCK_SPEED_HZ / BAUD_RATE;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BIT_TIMES * CLKS_PER_BIT;
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES);
  // The byte strobe lands one cycle after the stop-bit sample and the error
  // register adds one more, so the reload absorbs both to put frame_error
  // exactly TIMEOUT_CYCLES after the last byte completed.
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]       PAY_RELOAD = 4'(FRAME_PAYLOAD_BYTES - 1);

  logic          byte_valid, byte_framing_error;
  logic [7:0]    byte_data;
  parser_state_t state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [3:0]    pay_cnt;
  logic [7:0]    csum;
  logic [7:0]    motor_id;
  logic [111:0]  staging;
  logic          accept, reject, load_id, shift_en, tmr_done, id_bad;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clock              (clock),
    .reset              (reset),
    .rx                 (rx),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .byte_framing_error (byte_framing_error)
  );

  assign tmr_done = (tmr == '0);
  assign id_bad   = ({24'd0, byte_data} >= 32'(NUMBER_OF_MOTORS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    load_id   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      HUNT: begin
        if (byte_valid && byte_data == SYNC_BYTE) state_nxt = ID;
      end
      ID: begin
        if (byte_framing_error || (byte_valid && id_bad) || (!byte_valid && tmr_done)) begin
          reject    = 1'b1;
          state_nxt = HUNT;
        end else if (byte_valid) begin
          load_id   = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (byte_framing_error || (!byte_valid && tmr_done)) begin
          reject    = 1'b1;
          state_nxt = HUNT;
        end else if (byte_valid) begin
          shift_en = 1'b1;
          if (pay_cnt == '0) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (byte_framing_error || (!byte_valid && tmr_done)) begin
          reject    = 1'b1;
          state_nxt = HUNT;
        end else if (byte_valid) begin
          accept    = (byte_data == csum);
          reject    = (byte_data != csum);
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr      <= TMR_RELOAD;
      pay_cnt  <= '0;
      csum     <= '0;
      motor_id <= '0;
      staging  <= '0;
    end else begin
      if (byte_valid)
        tmr <= TMR_RELOAD;
      else if (state != HUNT && !tmr_done)
        tmr <= tmr - TMR_W'(1);

      if (load_id) begin
        motor_id <= byte_data;
        csum     <= byte_data;
        pay_cnt  <= PAY_RELOAD;
      end else if (shift_en) begin
        staging <= {staging[103:0], byte_data};
        csum    <= csum ^ byte_data;
        pay_cnt <= pay_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_valid        <= 1'b0;
      frame_error         <= 1'b0;
      status_motor        <= '0;
      status_position     <= '0;
      status_velocity     <= '0;
      status_displacement <= '0;
      status_current      <= '0;
      frame_count         <= '0;
    end else begin
      status_valid <= accept;
      frame_error  <= reject;
      if (accept) begin
        status_motor        <= motor_id;
        status_position     <= staging[111:80];
        status_velocity     <= staging[79:48];
        status_displacement <= staging[47:16];
        status_current      <= staging[15:0];
        frame_count         <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_icebus_status_rx.sv
module tb_icebus_status_rx;

  localparam int BIT = 25;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        status_valid;
  logic [7:0]  status_motor;
  logic [31:0] status_position;
  logic [31:0] status_velocity;
  logic [31:0] status_displacement;
  logic [15:0] status_current;
  logic        frame_error;
  logic [15:0] frame_count;

  icebus_status_rx dut (
    .clock               (clock),
    .reset               (reset),
    .rx                  (rx),
    .status_valid        (status_valid),
    .status_motor        (status_motor),
    .status_position     (status_position),
    .status_velocity     (status_velocity),
    .status_displacement (status_displacement),
    .status_current      (status_current),
    .frame_error         (frame_error),
    .frame_count         (frame_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // pulse monitor, sampled on the falling edge
  int          sv_cnt = 0, fe_cnt = 0, both_cnt = 0, fe_cyc = 0;
  logic [7:0]  snap_motor = '0;
  logic [31:0] snap_pos = '0;
  always @(negedge clock) begin
    if (status_valid) begin
      sv_cnt++;
      snap_motor = status_motor;
      snap_pos   = status_position;
    end
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (status_valid && frame_error) both_cnt++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  logic [7:0] frm [17];
  int         start_cyc = 0;
  int         b_sv, b_fe;

  task automatic build(input logic [7:0] id, input logic [31:0] p, input logic [31:0] v,
                       input logic [31:0] d, input logic [15:0] c, input logic [7:0] cx);
    frm[0]  = 8'h55;
    frm[1]  = id;
    for (int i = 0; i < 4; i++) begin
      frm[2 + i]  = p[31 - 8*i -: 8];
      frm[6 + i]  = v[31 - 8*i -: 8];
      frm[10 + i] = d[31 - 8*i -: 8];
    end
    frm[14] = c[15:8];
    frm[15] = c[7:0];
    frm[16] = cx;
    for (int i = 1; i < 16; i++) frm[16] ^= frm[i];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    rx = stop;
    repeat (BIT) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(frm[i], 1'b1);
  endtask

  task automatic mark();
    b_sv = sv_cnt;
    b_fe = fe_cnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    chk("rst_valid", 32'(status_valid), 32'd0);
    chk("rst_error", 32'(frame_error), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_pos",   status_position, 32'd0);
    chk("rst_cur",   32'(status_current), 32'd0);

    // good frame, ID 2
    mark();
    build(8'd2, 32'h0000_1234, 32'hFFFF_FF9C, 32'h0000_0010, 16'h8001, 8'h00);
    send_range(0, 16);
    repeat (10) @(negedge clock);
    chk("t1_pulses", 32'(sv_cnt - b_sv), 32'd1);
    chk("t1_errors", 32'(fe_cnt - b_fe), 32'd0);
    chk("t1_motor",  32'(status_motor), 32'd2);
    chk("t1_pos",    status_position, 32'h0000_1234);
    chk("t1_vel",    status_velocity, 32'hFFFF_FF9C);
    chk("t1_disp",   status_displacement, 32'h0000_0010);
    chk("t1_cur",    32'(status_current), 32'h0000_8001);
    chk("t1_count",  32'(frame_count), 32'd1);
    chk("t1_snap",   snap_pos, 32'h0000_1234);

    // noise, then two back-to-back good frames
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    build(8'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF, 16'h1234, 8'h00);
    send_range(0, 16);
    build(8'd4, 32'h0102_0304, 32'h5555_5555, 32'hFFFF_FFFF, 16'h7FFF, 8'h00);
    send_range(0, 16);
    repeat (10) @(negedge clock);
    chk("t2_errors", 32'(fe_cnt - b_fe), 32'd0);
    chk("t2_pulses", 32'(sv_cnt - b_sv), 32'd2);
    chk("t2_count",  32'(frame_count), 32'd3);
    chk("t2_motor",  32'(status_motor), 32'd4);
    chk("t2_vel",    status_velocity, 32'h5555_5555);
    chk("t2_cur",    32'(status_current), 32'h0000_7FFF);

    // good frame for highest ID, then a bad checksum copy
    mark();
    build(8'd5, 32'hCAFE_0001, 32'h0000_0002, 32'h0000_0003, 16'h0004, 8'h00);
    send_range(0, 16);
    build(8'd5, 32'h1111_1111, 32'h0000_0002, 32'h0000_0003, 16'h0004, 8'h01);
    send_range(0, 16);
    repeat (10) @(negedge clock);
    chk("t3_pulses", 32'(sv_cnt - b_sv), 32'd1);
    chk("t3_errors", 32'(fe_cnt - b_fe), 32'd1);
    chk("t3_count",  32'(frame_count), 32'd4);
    chk("t3_motor",  32'(status_motor), 32'd5);
    chk("t3_pos",    status_position, 32'hCAFE_0001);

    // out-of-range ID, then a good frame
    mark();
    build(8'd6, 32'h0, 32'h0, 32'h0, 16'h0, 8'h00);
    send_range(0, 1);
    repeat (10) @(negedge clock);
    chk("t4_errors",   32'(fe_cnt - b_fe), 32'd1);
    chk("t4_err_time", 32'(fe_cyc - start_cyc), 32'd241);
    build(8'd1, 32'h0000_0abc, 32'h0, 32'h0, 16'h0, 8'h00);
    send_range(0, 16);
    repeat (10) @(negedge clock);
    chk("t4_pulses", 32'(sv_cnt - b_sv), 32'd1);
    chk("t4_count",  32'(frame_count), 32'd5);
    chk("t4_pos",    status_position, 32'h0000_0ABC);

    // framing error in byte 5; no later timeout may follow
    mark();
    build(8'd3, 32'h0F0F_0F0F, 32'h0, 32'h0, 16'h0, 8'h00);
    send_range(0, 4);
    send_byte(frm[5], 1'b0);
    repeat (1200) @(negedge clock);
    chk("t5_errors",   32'(fe_cnt - b_fe), 32'd1);
    chk("t5_err_time", 32'(fe_cyc - start_cyc), 32'd241);
    chk("t5_pulses",   32'(sv_cnt - b_sv), 32'd0);
    chk("t5_count",    32'(frame_count), 32'd5);

    // inter-byte timeout after byte 8
    mark();
    send_range(0, 8);
    repeat (1300) @(negedge clock);
    chk("t6_errors",   32'(fe_cnt - b_fe), 32'd1);
    chk("t6_err_time", 32'(fe_cyc - start_cyc), 32'd1240);
    chk("t6_pos",      status_position, 32'h0000_0ABC);

    // 10-cycle low glitch between sync and ID must not produce a byte
    mark();
    build(8'd3, 32'h0000_0033, 32'h0, 32'h0, 16'h0, 8'h00);
    send_range(0, 0);
    repeat (5) @(negedge clock);
    rx = 1'b0;
    repeat (10) @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
    send_range(1, 16);
    repeat (10) @(negedge clock);
    chk("t7_pulses", 32'(sv_cnt - b_sv), 32'd1);
    chk("t7_errors", 32'(fe_cnt - b_fe), 32'd0);
    chk("t7_motor",  32'(status_motor), 32'd3);
    chk("t7_count",  32'(frame_count), 32'd6);

    // reset mid-payload, then a fresh frame
    build(8'd2, 32'h2222_2222, 32'h0, 32'h0, 16'h0, 8'h00);
    send_range(0, 7);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("t8_rst_count", 32'(frame_count), 32'd0);
    chk("t8_rst_motor", 32'(status_motor), 32'd0);
    chk("t8_rst_pos",   status_position, 32'd0);
    mark();
    send_range(0, 16);
    repeat (10) @(negedge clock);
    chk("t8_pulses", 32'(sv_cnt - b_sv), 32'd1);
    chk("t8_count",  32'(frame_count), 32'd1);
    chk("t8_pos",    status_position, 32'h2222_2222);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
